// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences one vector operation at a time over pe_array.
// It streams operand reads, holds instr/alg steady, and strobes result
// writes as beats leave the fixed-latency read + PE pipeline.
module pe_array_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9,
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_instr,
    input  logic [4:0]        cmd_alg,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [4:0]        pe_instr,
    output logic [4:0]        pe_alg,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int TOT = RD_LAT + PE_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, iss_cnt_q, wr_cnt_q;
    logic              rd_en_q, done_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [4:0]        instr_q, alg_q;
    // vld_q[k] is rd_en delayed by k+1 cycles; the top tap is the write strobe
    logic [TOT-1:0]    vld_q;
    logic              last_iss, last_wr;

    // iss_cnt_q indexes the beat currently presented on rd_en/rd_addr
    assign last_iss = (iss_cnt_q == len_q - LEN_W'(1));
    assign last_wr  = vld_q[TOT-1] && (wr_cnt_q == len_q - LEN_W'(1));

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = (cmd_len == '0) ? DONE : ISSUE;
            ISSUE:   if (last_iss) state_d = DRAIN;
            DRAIN:   if (last_wr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: command latch, read issue, valid pipeline, write-back counters
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            iss_cnt_q <= '0;
            wr_cnt_q  <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            instr_q   <= 5'd31;
            alg_q     <= 5'd0;
            vld_q     <= '0;
        end else begin
            vld_q[0] <= rd_en_q;
            for (int i = 1; i < TOT; i++) vld_q[i] <= vld_q[i-1];

            done_q <= (state_d == DONE);

            // Post-increment so the address is ready for the next write beat
            if (vld_q[TOT-1]) begin
                wr_cnt_q  <= wr_cnt_q + LEN_W'(1);
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        instr_q   <= cmd_instr;
                        alg_q     <= cmd_alg;
                        len_q     <= cmd_len;
                        iss_cnt_q <= '0;
                        wr_cnt_q  <= '0;
                        rd_addr_q <= cmd_src;
                        wr_addr_q <= cmd_dst;
                        rd_en_q   <= (cmd_len != '0);
                    end
                end
                ISSUE: begin
                    if (last_iss) begin
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        iss_cnt_q <= iss_cnt_q + LEN_W'(1);
                    end
                end
                default: rd_en_q <= 1'b0;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pe_instr  = instr_q;
    assign pe_alg    = alg_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = vld_q[TOT-1];
    assign wr_addr   = wr_addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: reset values, a normal run, len=0,
// address wrap, busy rejection and reset mid-operation.
module tb_pe_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_instr, cmd_alg;
    logic [7:0] cmd_src, cmd_dst;
    logic [8:0] cmd_len;
    logic [4:0] pe_instr, pe_alg;
    logic       rd_en, wr_en, busy, done;
    logic [7:0] rd_addr, wr_addr;

    int checks = 0;
    int passes = 0;

    // TOT = RD_LAT + PE_LAT = 7
    localparam int TOT = 7;

    pe_array_ctrl #(.ADDR_W(8), .LEN_W(9), .RD_LAT(1), .PE_LAT(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_alg(cmd_alg),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .pe_instr(pe_instr), .pe_alg(pe_alg),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One cycle advance; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    endtask

    task automatic drive(input logic [4:0] ins, input logic [4:0] al,
                         input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        cmd_valid = 1'b1;
        cmd_instr = ins;
        cmd_alg   = al;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
    endtask

    // Offer a command in the current (idle) cycle A=0 and check every cycle
    // up to and including the one where cmd_ready returns.
    task automatic run_cmd(input logic [4:0] ins, input logic [4:0] al,
                           input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        int   len, last;
        logic exp_rd, exp_wr, exp_done, exp_rdy;
        logic [7:0] ea;
        len  = int'(l);
        last = (len == 0) ? 2 : len + TOT + 2;
        drive(ins, al, s, d, l);
        chk("accept_ready", 0, 32'(cmd_ready), 32'd1);
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            exp_rd   = (c >= 1) && (c <= len);
            exp_wr   = (c >= 1 + TOT) && (c <= len + TOT);
            exp_done = (len == 0) ? (c == 1) : (c == len + TOT + 1);
            exp_rdy  = (c == last);
            chk("rd_en", c, 32'(rd_en), 32'(exp_rd));
            chk("wr_en", c, 32'(wr_en), 32'(exp_wr));
            chk("done", c, 32'(done), 32'(exp_done));
            chk("cmd_ready", c, 32'(cmd_ready), 32'(exp_rdy));
            chk("busy", c, 32'(busy), 32'(!exp_rdy));
            chk("pe_instr", c, 32'(pe_instr), 32'(ins));
            chk("pe_alg", c, 32'(pe_alg), 32'(al));
            if (exp_rd) begin
                ea = s + 8'(c - 1);
                chk("rd_addr", c, 32'(rd_addr), 32'(ea));
            end
            if (exp_wr) begin
                ea = d + 8'(c - 1 - TOT);
                chk("wr_addr", c, 32'(wr_addr), 32'(ea));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_instr = '0;
        cmd_alg   = '0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;

        // Reset held two cycles, then every output at its reset value
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 0, 32'(cmd_ready), 32'd1);
        chk("rst_busy",      0, 32'(busy),      32'd0);
        chk("rst_done",      0, 32'(done),      32'd0);
        chk("rst_rd_en",     0, 32'(rd_en),     32'd0);
        chk("rst_wr_en",     0, 32'(wr_en),     32'd0);
        chk("rst_rd_addr",   0, 32'(rd_addr),   32'd0);
        chk("rst_wr_addr",   0, 32'(wr_addr),   32'd0);
        chk("rst_pe_instr",  0, 32'(pe_instr),  32'd31);
        chk("rst_pe_alg",    0, 32'(pe_alg),    32'd0);

        // KMUL, KEM_512, src=0x10, dst=0x80, len=4
        run_cmd(5'd5, 5'd0, 8'h10, 8'h80, 9'd4);

        // len=0 NTT: done at A+1, no traffic, instr sticks afterwards
        run_cmd(5'd7, 5'd1, 8'h33, 8'h44, 9'd0);
        tick();
        chk("len0_instr_after", 0, 32'(pe_instr), 32'd7);
        chk("len0_alg_after",   0, 32'(pe_alg),   32'd1);

        // Address wrap at both ends
        run_cmd(5'd5, 5'd2, 8'hFE, 8'hFF, 9'd3);

        // Busy rejection: MMUL held from cycle 2 of a len=4 KMUL
        drive(5'd5, 5'd0, 8'h10, 8'h80, 9'd4);
        for (int c = 1; c <= 23; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            if (c == 2) drive(5'd2, 5'd3, 8'h20, 8'h40, 9'd1);
            if (c == 14) cmd_valid = 1'b0;
            chk("rej_ready", c, 32'(cmd_ready), 32'(c == 13 || c == 23));
            chk("rej_instr", c, 32'(pe_instr), (c <= 13) ? 32'd5 : 32'd2);
            chk("rej_done",  c, 32'(done), 32'(c == 12 || c == 22));
            chk("rej_wr_en", c, 32'(wr_en), 32'((c >= 8 && c <= 11) || c == 21));
            if (c == 21) chk("rej_wr_addr", c, 32'(wr_addr), 32'h40);
            if (c == 14) chk("rej_rd_addr", c, 32'(rd_addr), 32'h20);
        end

        // Reset mid-operation at cycle 6 of a len=4 command
        drive(5'd5, 5'd0, 8'h10, 8'h80, 9'd4);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            if (c == 7) rst = 1'b0;
            if (c >= 7) begin
                chk("mrst_ready",  c, 32'(cmd_ready), 32'd1);
                chk("mrst_wr_en",  c, 32'(wr_en),     32'd0);
                chk("mrst_done",   c, 32'(done),      32'd0);
                chk("mrst_rd_en",  c, 32'(rd_en),     32'd0);
            end else begin
                chk("mrst_busy",   c, 32'(busy),      32'd1);
                chk("mrst_rd_en",  c, 32'(rd_en),     32'(c <= 4));
            end
            if (c == 7) chk("mrst_instr", c, 32'(pe_instr), 32'd31);
            if (c == 6) rst = 1'b1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
